// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: control-bus layout,
// bubble encoding and the occupancy state type.
package pipe_pkg;

    localparam int unsigned CTRL_W = 12;

    // Control bus bit positions
    localparam int unsigned CTRL_BR     = 11;
    localparam int unsigned CTRL_JMP    = 10;
    localparam int unsigned CTRL_JMPMEM = 9;
    localparam int unsigned CTRL_MRD    = 8;
    localparam int unsigned CTRL_M2R    = 7;
    localparam int unsigned CTRL_MWR    = 6;
    localparam int unsigned CTRL_ALUSRC = 5;
    localparam int unsigned CTRL_RWR    = 4;
    localparam int unsigned CTRL_ALUOP_HI = 3;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One held pipeline word (ctrl + operands + rd) with load enable and a
// synchronous clear to the bubble encoding.
module pipe_stage_entry #(
    parameter int unsigned       CTRL_W      = pipe_pkg::CTRL_W,
    parameter int unsigned       WORD_W      = 128,
    parameter int unsigned       RD_W        = 5,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = pipe_pkg::CTRL_BUBBLE
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [WORD_W-1:0] i_data,
    input  logic [RD_W-1:0]   i_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [WORD_W-1:0] o_data,
    output logic [RD_W-1:0]   o_rd
);
    import pipe_pkg::*;

    logic [CTRL_W-1:0] r_ctrl;
    logic [WORD_W-1:0] r_data;
    logic [RD_W-1:0]   r_rd;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ctrl <= CTRL_BUBBLE;
            r_data <= '0;
            r_rd   <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
            r_rd   <= i_rd;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;
    assign o_rd   = r_rd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble. Optional PIPE_STAGE_STATS_EN adds stall/flush counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       N_DATA      = 4,
    parameter int unsigned       CTRL_W      = pipe_pkg::CTRL_W,
    parameter int unsigned       RD_W        = 5,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = pipe_pkg::CTRL_BUBBLE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]          in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]          out_rd
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              flush_cnt
`endif
);
    import pipe_pkg::*;

    localparam int unsigned WORD_W = N_DATA * DATA_W;

    state_e r_state;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_send;
    logic              w_main_load;
    logic              w_skid_load;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [WORD_W-1:0] w_main_data_d;
    logic [RD_W-1:0]   w_main_rd_d;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [WORD_W-1:0] w_main_data;
    logic [RD_W-1:0]   w_main_rd;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [WORD_W-1:0] w_skid_data;
    logic [RD_W-1:0]   w_skid_rd;

    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    // A flush cycle drops any concurrent upstream word
    assign w_accept    = in_valid & w_in_ready & ~flush;
    assign w_send      = w_out_valid & out_ready;

    assign w_main_load = ((r_state == ST_EMPTY) & w_accept)
                       | ((r_state == ST_ONE) & w_accept & w_send)
                       | ((r_state == ST_FULL) & w_send);
    assign w_skid_load = (r_state == ST_ONE) & w_accept & ~w_send;

    always_comb begin
        w_main_ctrl_d = in_ctrl;
        w_main_data_d = in_data;
        w_main_rd_d   = in_rd;
        if (r_state == ST_FULL) begin
            w_main_ctrl_d = w_skid_ctrl;
            w_main_data_d = w_skid_data;
            w_main_rd_d   = w_skid_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_send)      r_state <= ST_FULL;
                    else if (!w_accept && w_send) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_send) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    pipe_stage_entry #(
        .CTRL_W      (CTRL_W),
        .WORD_W      (WORD_W),
        .RD_W        (RD_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk    (clk),
        .i_clr  (rst),
        .i_load (w_main_load),
        .i_ctrl (w_main_ctrl_d),
        .i_data (w_main_data_d),
        .i_rd   (w_main_rd_d),
        .o_ctrl (w_main_ctrl),
        .o_data (w_main_data),
        .o_rd   (w_main_rd)
    );

    pipe_stage_entry #(
        .CTRL_W      (CTRL_W),
        .WORD_W      (WORD_W),
        .RD_W        (RD_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk    (clk),
        .i_clr  (rst),
        .i_load (w_skid_load),
        .i_ctrl (in_ctrl),
        .i_data (in_data),
        .i_rd   (in_rd),
        .o_ctrl (w_skid_ctrl),
        .o_data (w_skid_data),
        .o_rd   (w_skid_rd)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // Entries may hold stale words after a flush, so mask them while empty
    assign out_ctrl  = w_out_valid ? w_main_ctrl : CTRL_BUBBLE;
    assign out_rd    = w_out_valid ? w_main_rd : '0;
    assign out_data  = w_main_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush && (r_state != ST_EMPTY) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed words are queued on accept and a
// negedge monitor pops and compares every word the stage delivers.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_DATA = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned WORD_W = DATA_W * N_DATA;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [WORD_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [WORD_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .N_DATA      (N_DATA),
        .CTRL_W      (CTRL_W),
        .RD_W        (RD_W),
        .CTRL_BUBBLE (12'h000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_rd    (out_rd)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [WORD_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } word_t;

    word_t sb[$];
    word_t mon_exp;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_pushed = 0;
    int    n_popped = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed word k: distinct control pattern, operand j = 0x100 + k + (j << 16)
    function automatic word_t mk_word(input int k);
        word_t w;
        w = '0;
        w.ctrl[CTRL_RWR]    = 1'b1;
        w.ctrl[CTRL_ALUSRC] = 1'b1;
        w.ctrl[CTRL_BR]     = k[0];
        w.ctrl[CTRL_JMP]    = k[1];
        w.ctrl[CTRL_JMPMEM] = k[2];
        w.ctrl[CTRL_MRD]    = ~k[0];
        w.ctrl[CTRL_M2R]    = k[3];
        w.ctrl[CTRL_MWR]    = k[1] ^ k[0];
        w.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = k[3:0];
        for (int j = 0; j < int'(N_DATA); j++)
            w.data[j*DATA_W +: DATA_W] = 32'(32'h100 + k + (j << 16));
        w.rd = RD_W'(k);
        return w;
    endfunction

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input int k);
        word_t w;
        w = mk_word(k);
        in_ctrl = w.ctrl;
        in_data = w.data;
        in_rd   = w.rd;
    endtask

    // Present word k, wait (bounded) for acceptance, queue its expected image
    task automatic send(input int k);
        int waited;
        waited = 0;
        drive_word(k);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for word %0d", k);
        end else begin
            sb.push_back(mk_word(k));
            n_pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) begin
                chk("bubble_ctrl", WORD_W'(out_ctrl), '0);
                chk("bubble_rd", WORD_W'(out_rd), '0);
            end else if (out_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got rd=%0d expected no output", out_rd);
                end else begin
                    mon_exp = sb.pop_front();
                    n_popped++;
                    chk("sb_ctrl", WORD_W'(out_ctrl), WORD_W'(mon_exp.ctrl));
                    chk("sb_data", out_data, mon_exp.data);
                    chk("sb_rd", WORD_W'(out_rd), WORD_W'(mon_exp.rd));
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1;
        drive_word(31);

        // Reset with in_valid held high
        tick(2);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", WORD_W'(out_valid), 0);
        chk("rst_out_ctrl", WORD_W'(out_ctrl), 0);
        chk("rst_out_rd", WORD_W'(out_rd), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", WORD_W'(in_ready), 1);
        tick(1);
        chk("rst_idle_valid", WORD_W'(out_valid), 0);

        // Streaming at full throughput
        for (int k = 1; k <= 8; k++) begin
            send(k);
            chk("stream_valid", WORD_W'(out_valid), 1);
            chk("stream_rd", WORD_W'(out_rd), WORD_W'(k));
            chk("stream_in_ready", WORD_W'(in_ready), 1);
        end
        tick(2);
        chk("stream_drained", WORD_W'(out_valid), 0);

        // Stall into skid, then release
        out_ready = 1'b0;
        send(3);
        chk("skid_one_ready", WORD_W'(in_ready), 1);
        send(4);
        chk("skid_full_ready", WORD_W'(in_ready), 0);
        chk("skid_full_rd", WORD_W'(out_rd), 3);
        tick(2);
        chk("skid_hold_rd", WORD_W'(out_rd), 3);
        chk("skid_hold_data", out_data, mk_word(3).data);
        chk("skid_hold_valid", WORD_W'(out_valid), 1);
        out_ready = 1'b1;
        tick(1);
        chk("skid_release_ready", WORD_W'(in_ready), 1);
        chk("skid_release_rd", WORD_W'(out_rd), 4);
        tick(1);
        chk("skid_release_empty", WORD_W'(out_valid), 0);

        // Flush while FULL with a word offered
        out_ready = 1'b0;
        send(5);
        send(6);
        chk("flush_pre_full", WORD_W'(in_ready), 0);
        drive_word(9);
        in_valid = 1'b1; flush = 1'b1;
        sb.delete();
        tick(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", WORD_W'(out_valid), 0);
        chk("flush_full_ctrl", WORD_W'(out_ctrl), 0);
        chk("flush_full_rd", WORD_W'(out_rd), 0);
        chk("flush_full_ready", WORD_W'(in_ready), 1);
        out_ready = 1'b1;
        tick(3);

        // Flush in ONE with an acceptable word offered: both dropped
        out_ready = 1'b0;
        send(11);
        drive_word(10);
        in_valid = 1'b1; flush = 1'b1;
        sb.delete();
        tick(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_one_valid", WORD_W'(out_valid), 0);
        out_ready = 1'b1;
        tick(3);

        // Reset together with flush mid-stall
        out_ready = 1'b0;
        send(7);
        send(8);
        tick(1);
        drive_word(12);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        sb.delete();
        tick(1);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rstflush_valid", WORD_W'(out_valid), 0);
        chk("rstflush_ready", WORD_W'(in_ready), 1);
        chk("rstflush_ctrl", WORD_W'(out_ctrl), 0);
        chk("rstflush_rd", WORD_W'(out_rd), 0);
        chk("rstflush_data", out_data, 0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rstflush_stall_cnt", WORD_W'(stall_cnt), 0);
        chk("rstflush_flush_cnt", WORD_W'(flush_cnt), 0);
`endif
        out_ready = 1'b1;
        tick(2);

`ifdef PIPE_STAGE_STATS_EN
        // Four stalled cycles plus a stalled flush cycle = 5 stalls, 1 squash
        out_ready = 1'b0;
        send(13);
        tick(4);
        flush = 1'b1;
        sb.delete();
        tick(1);
        flush = 1'b0;
        chk("stats_stall5", WORD_W'(stall_cnt), 5);
        chk("stats_flush1", WORD_W'(flush_cnt), 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("stats_flush_empty", WORD_W'(flush_cnt), 1);
        send(14);
        tick(70000);
        chk("stats_stall_sat", WORD_W'(stall_cnt), 16'hFFFF);
        rst = 1'b1;
        sb.delete();
        tick(1);
        rst = 1'b0;
        chk("stats_rst_clear", WORD_W'(stall_cnt), 0);
        out_ready = 1'b1;
        tick(2);
`endif

        tick(3);
        chk("sb_empty", WORD_W'(sb.size()), 0);
        chk("delivered_count", WORD_W'(n_popped), 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed ID/EX latch. It carries a control bus, N data operands and a destination-register index between CPU stages. Adds a valid/ready handshake with a 2-entry skid buffer (full throughput, registered in_ready), stall, and flush-to-bubble. It is instantiated for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
DATA_W, 32, width of each data operand
N_DATA, 4, number of data operands (ID/EX: rs1, rs2, imm, pc)
CTRL_W, 12, control bus width (branch, jump, jumpMem, memRead, memToReg, memWrite, aluSrc, regWrt, aluOp[3:0])
RD_W, 5, destination register index width
CTRL_BUBBLE, 0, CTRL_W-bit control value presented for a bubble

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries, insert bubble
in_valid  in  1  upstream word valid
in_ready  out  1  stage can accept a word this cycle
in_ctrl  in  CTRL_W  control fields
in_data  in  N_DATA*DATA_W  operands, operand k at [k*DATA_W +: DATA_W]
in_rd  in  RD_W  destination index
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control; CTRL_BUBBLE whenever out_valid=0
out_data  out  N_DATA*DATA_W  operands
out_rd  out  RD_W  destination index; 0 whenever out_valid=0

Behaviour:
- Accept = in_valid & in_ready. Send = out_valid & out_ready.
- State register: EMPTY, ONE (main entry valid), FULL (main and skid entries valid).
- in_ready = (state != FULL). It is a pure function of registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY). The output comes from the main entry only.
- EMPTY: accept -> ONE, word loads into main. Latency is 1 cycle from accept to out_valid.
- ONE:
  - accept & send -> ONE, main is replaced by the new word.
  - accept & !send -> FULL, new word goes to skid.
  - !accept & send -> EMPTY.
  - otherwise hold.
- FULL: send -> ONE, skid moves to main. Otherwise hold (stall). No accept is possible in FULL.
- Order is strictly FIFO. No word is duplicated or lost except by flush.
- flush=1: next state is EMPTY. Any accept in the same cycle is dropped. Entry data registers may hold stale values, but out_ctrl=CTRL_BUBBLE and out_rd=0 are forced while empty.
- rst=1: state EMPTY; main and skid ctrl=CTRL_BUBBLE, rd=0, data=0.
- Priority: rst > flush > normal operation.
- A reset or flush mid-stall discards both entries. out_valid=0 on the following cycle.
- Held values are stable while out_valid & !out_ready.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt counts cycles with out_valid & !out_ready.
  - flush_cnt counts cycles with flush=1 and state != EMPTY (real squashes only).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W and the bit offsets of each control field (BR, JMP, JMPMEM, MRD, M2R, MWR, ALUSRC, RWR, ALUOP[3:0]).
  - CTRL_BUBBLE.
  - The state encoding typedef (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
- One sub-module, pipe_stage_entry: a word register (ctrl+data+rd) with load enable and synchronous clear. It is instantiated twice, as main and skid.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_rd=0, in_ready=1 the cycle after rst falls.
2. Streaming: out_ready=1, push words with rd=1..8, data=32'h100+k -> each appears 1 cycle later in order. in_ready stays 1 and one word completes per cycle.
3. Stall/skid: push rd=3 then rd=4 with out_ready=0 -> state FULL, in_ready=0, out_rd=3 held. Raise out_ready -> rd=3 then rd=4 delivered, in_ready=1 one cycle after the first send.
4. Flush while FULL with in_valid=1 (rd=9) -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE. rd=9 is never delivered.
5. rst and flush asserted together with rst mid-stall -> same result as rst alone. With PIPE_STAGE_STATS_EN, stall_cnt=0 and flush_cnt=0.
6. PIPE_STAGE_STATS_EN: stall 5 cycles then flush a held word -> stall_cnt=5, flush_cnt=1. Forcing 70000 stall cycles -> stall_cnt=16'hFFFF.
